mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the CPU's instruction-fetch port and its load/store port.
- One transaction is outstanding at a time.
- Data requests have priority over fetch requests. A starvation limit guarantees fetch progress.
- A response timeout stops a hung memory from deadlocking the core. Sits between the cpu datapath and the memory model.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch port
// and the load/store port, with one transaction outstanding at a time.
// Data requests have priority. A streak counter forces a fetch grant after
// MAX_STREAK back-to-back data grants taken while a fetch was waiting.
// A response timeout turns a hung memory into an error response.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   if_req/if_addr        fetch request in; if_gnt (comb), if_rvalid/if_rdata out
//   d_req/d_addr/d_we/d_be/d_wdata  data request in; d_gnt (comb), d_rvalid/d_rdata out
//   mem_req/mem_addr/mem_we/mem_be/mem_wdata  latched request to memory
//   mem_gnt/mem_rvalid/mem_rdata              memory handshake and response
//   err                   one-cycle pulse when a response times out
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err
);

    localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    state_t                r_state;
    state_t                w_state_nxt;
    owner_t                r_owner;
    logic [STREAK_W-1:0]   r_streak;
    logic [STREAK_W-1:0]   w_streak_nxt;
    logic [TMO_W-1:0]      r_tmo;
    logic [TMO_W-1:0]      w_tmo_nxt;

    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  r_mem_we;
    logic [3:0]            r_mem_be;
    logic [DATA_WIDTH-1:0] r_mem_wdata;

    logic                  r_if_rvalid;
    logic                  r_d_rvalid;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_err;

    logic                  w_if_gnt;
    logic                  w_d_gnt;
    logic                  w_if_rvalid_nxt;
    logic                  w_d_rvalid_nxt;
    logic [DATA_WIDTH-1:0] w_if_rdata_nxt;
    logic [DATA_WIDTH-1:0] w_d_rdata_nxt;
    logic                  w_err_nxt;
    logic                  w_rsp;
    logic [DATA_WIDTH-1:0] w_rsp_data;

    // Next state, arbitration and response generation
    always_comb begin
        w_state_nxt     = r_state;
        w_streak_nxt    = r_streak;
        w_tmo_nxt       = r_tmo;
        w_if_gnt        = 1'b0;
        w_d_gnt         = 1'b0;
        w_rsp           = 1'b0;
        w_rsp_data      = '0;
        w_err_nxt       = 1'b0;
        w_if_rvalid_nxt = 1'b0;
        w_d_rvalid_nxt  = 1'b0;
        w_if_rdata_nxt  = '0;
        w_d_rdata_nxt   = '0;

        case (r_state)
            S_IDLE: begin
                // Fetch wins alone, or when the data streak has hit its limit
                if (if_req && (!d_req || r_streak == STREAK_W'(MAX_STREAK))) begin
                    w_if_gnt     = 1'b1;
                    w_streak_nxt = '0;
                    w_state_nxt  = S_ISSUE;
                end else if (d_req) begin
                    w_d_gnt = 1'b1;
                    if (!if_req) begin
                        w_streak_nxt = '0;
                    end else if (r_streak != STREAK_W'(MAX_STREAK)) begin
                        w_streak_nxt = r_streak + STREAK_W'(1);
                    end
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    w_tmo_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // A real response takes precedence over a same-cycle timeout
                if (mem_rvalid) begin
                    w_rsp       = 1'b1;
                    w_rsp_data  = r_mem_we ? '0 : mem_rdata;
                    w_state_nxt = S_IDLE;
                end else if (r_tmo == TMO_W'(TIMEOUT)) begin
                    w_rsp       = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo + TMO_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Route the response to whichever port owns the transaction
        if (w_rsp) begin
            if (r_owner == OWN_D) begin
                w_d_rvalid_nxt = 1'b1;
                w_d_rdata_nxt  = w_rsp_data;
            end else begin
                w_if_rvalid_nxt = 1'b1;
                w_if_rdata_nxt  = w_rsp_data;
            end
        end
    end

    // State, counters, latched request and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_streak    <= '0;
            r_tmo       <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_streak    <= w_streak_nxt;
            r_tmo       <= w_tmo_nxt;
            r_if_rvalid <= w_if_rvalid_nxt;
            r_d_rvalid  <= w_d_rvalid_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err       <= w_err_nxt;
            if (w_if_gnt) begin
                r_owner     <= OWN_IF;
                r_mem_addr  <= if_addr;
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'hF;
                r_mem_wdata <= '0;
            end else if (w_d_gnt) begin
                r_owner     <= OWN_D;
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_be    <= d_be;
                r_mem_wdata <= d_wdata;
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign d_gnt     = w_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = (r_state == S_ISSUE);
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single fetch, delayed store,
// contention ordering, timeout, reset mid-transaction, dropped request.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_gnt   (mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    logic [138:0] w_all_outs;
    assign w_all_outs = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
                         mem_req, mem_addr, mem_we, mem_be, mem_wdata, err};

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    endtask

    // Step into the next cycle; inputs are driven just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both requesters held high against a zero-latency memory; the first
    // nchk grants must follow D,D,D,D,I,...
    task automatic run_contention(input int ncyc, input int nchk);
        logic        pend;
        logic        dbl;
        logic [31:0] order;
        int          idx;
        pend  = 1'b0;
        dbl   = 1'b0;
        order = '0;
        idx   = 0;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if_req     = (c < ncyc - 6);
            d_req      = (c < ncyc - 6);
            d_we       = 1'b0;
            if_addr    = 32'(c * 4);
            d_addr     = 32'h400 + 32'(c * 4);
            mem_gnt    = mem_req;
            mem_rvalid = pend;
            mem_rdata  = 32'(c);
            @(negedge clk);
            if (if_gnt && d_gnt) dbl = 1'b1;
            if (if_gnt || d_gnt) begin
                if (idx < 32) order[idx] = if_gnt;
                idx++;
            end
            pend = mem_req && mem_gnt;
        end
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("cont_no_double_gnt", 160'(dbl), 160'(0));
        check("cont_grant_count", 160'(idx >= nchk), 160'(1));
        for (int k = 0; k < nchk; k++) begin
            check($sformatf("cont_order_%0d", k), 160'(order[k]), 160'((k % 5) == 4));
        end
    endtask

    initial begin
        logic early;
        reset      = 1'b1;
        if_req     = 1'b0;
        if_addr    = '0;
        d_req      = 1'b0;
        d_addr     = '0;
        d_we       = 1'b0;
        d_be       = '0;
        d_wdata    = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset
        tick();
        tick();
        @(negedge clk);
        check("reset_outputs", 160'(w_all_outs), 160'(0));
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", 160'(w_all_outs), 160'(0));

        // Single fetch, minimum latency
        tick();
        if_req  = 1'b1;
        if_addr = 32'h8;
        @(negedge clk);
        check("fetch_gnt", 160'({if_gnt, d_gnt}), 160'(2'b10));
        tick();
        if_req  = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("fetch_issue", 160'({mem_req, mem_we, mem_addr}), 160'({1'b1, 1'b0, 32'h8}));
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h00100093;
        @(negedge clk);
        check("fetch_req_dropped", 160'(mem_req), 160'(0));
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("fetch_rsp", 160'({if_rvalid, if_rdata, d_rvalid}), 160'({1'b1, 32'h00100093, 1'b0}));
        tick();
        @(negedge clk);
        check("fetch_rvalid_pulse", 160'(if_rvalid), 160'(0));

        // Store with mem_gnt delayed three cycles
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h100;
        d_be    = 4'hF;
        d_wdata = 32'hDEADBEEF;
        @(negedge clk);
        check("store_gnt", 160'({if_gnt, d_gnt}), 160'(2'b01));
        for (int k = 0; k < 4; k++) begin
            tick();
            d_req   = 1'b0;
            d_addr  = 32'h0;
            d_wdata = 32'h0;
            d_be    = 4'h0;
            mem_gnt = (k == 3);
            @(negedge clk);
            check($sformatf("store_hold_%0d", k),
                  160'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}),
                  160'({1'b1, 1'b1, 4'hF, 32'h100, 32'hDEADBEEF}));
        end
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        @(negedge clk);
        check("store_wait", 160'({mem_req, d_rvalid}), 160'(0));
        tick();
        mem_rvalid = 1'b0;
        d_we       = 1'b0;
        @(negedge clk);
        check("store_ack", 160'({d_rvalid, d_rdata, if_rvalid}), 160'({1'b1, 32'h0, 1'b0}));

        // Contention
        run_contention(40, 10);

        // Timeout on a load
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        @(negedge clk);
        check("tmo_gnt", 160'(d_gnt), 160'(1));
        tick();
        d_req     = 1'b0;
        mem_gnt   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        tick();
        mem_gnt = 1'b0;
        early   = 1'b0;
        for (int i = 0; i < 65; i++) begin
            @(negedge clk);
            if (err || d_rvalid || if_rvalid) early = 1'b1;
            tick();
        end
        @(negedge clk);
        check("tmo_no_early_rsp", 160'(early), 160'(0));
        check("tmo_err_rsp", 160'({err, d_rvalid, d_rdata, if_rvalid}), 160'({1'b1, 1'b1, 32'h0, 1'b0}));
        tick();
        @(negedge clk);
        check("tmo_err_pulse", 160'({err, d_rvalid}), 160'(0));
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("tmo_late_ignored", 160'({err, d_rvalid, if_rvalid, mem_req}), 160'(0));

        // Reset while in WAIT
        tick();
        if_req  = 1'b1;
        if_addr = 32'h40;
        @(negedge clk);
        check("rst_fetch_gnt", 160'(if_gnt), 160'(1));
        tick();
        if_req  = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        reset   = 1'b1;
        tick();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h77777777;
        @(negedge clk);
        check("rst_all_zero", 160'(w_all_outs), 160'(0));
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_no_rsp", 160'({if_rvalid, d_rvalid, err}), 160'(0));
        tick();
        if_req  = 1'b1;
        if_addr = 32'h44;
        @(negedge clk);
        check("rst_next_gnt", 160'(if_gnt), 160'(1));
        tick();
        if_req  = 1'b0;
        mem_gnt = 1'b1;
        @(negedge clk);
        check("rst_next_issue", 160'({mem_req, mem_addr}), 160'({1'b1, 32'h44}));
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE0001;
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("rst_next_rsp", 160'({if_rvalid, if_rdata}), 160'({1'b1, 32'hCAFE0001}));

        // Fetch request dropped while a load is in WAIT
        tick();
        d_req  = 1'b1;
        d_addr = 32'h300;
        @(negedge clk);
        check("drop_d_gnt", 160'(d_gnt), 160'(1));
        tick();
        d_req   = 1'b0;
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        if_req  = 1'b1;
        @(negedge clk);
        check("drop_no_if_gnt_wait", 160'(if_gnt), 160'(0));
        tick();
        if_req     = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BADF00D;
        @(negedge clk);
        check("drop_no_if_gnt_after", 160'(if_gnt), 160'(0));
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("drop_d_rsp", 160'({d_rvalid, d_rdata, if_rvalid}), 160'({1'b1, 32'h0BADF00D, 1'b0}));
        // Streak still at zero: four data grants precede the forced fetch
        run_contention(22, 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
